// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding, default widths and port ids for mem_arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  localparam int AW_DEF = 16;
  localparam int DW_DEF = 16;
  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (fetch/data) arbiter onto a single-cycle memory, one transaction per 3 cycles
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int FIX_PRIO = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          p0_req,
  input  logic [AW-1:0] p0_addr,
  output logic          p0_ack,
  output logic [DW-1:0] p0_rdata,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_ack,
  output logic [DW-1:0] p1_rdata,
  output logic          mem_MemWrite,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_write_data,
  input  logic [DW-1:0] mem_read_data
);
  state_t state, state_nx;
  logic cmd_id, cmd_we, last, pick, start;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  always_comb begin
    start = state == IDLE && (p0_req || p1_req);
    pick = (p0_req && p1_req) ? ((FIX_PRIO != 0) ? PORT0 : ~last) : p1_req;
    state_nx = start ? ACCESS : state == ACCESS ? RESP : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  // last starts at port 1 so that port 0 wins the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_id <= PORT0;
      cmd_we <= 1'b0;
      cmd_addr <= '0;
      cmd_wdata <= '0;
      last <= PORT1;
      p0_rdata <= '0;
      p1_rdata <= '0;
    end else begin
      if (start) begin
        cmd_id <= pick;
        cmd_we <= pick & p1_we;
        cmd_addr <= pick ? p1_addr : p0_addr;
        cmd_wdata <= pick ? p1_wdata : '0;
        last <= pick;
      end
      if (state == ACCESS && cmd_id == PORT1) p1_rdata <= mem_read_data;
      if (state == ACCESS && cmd_id == PORT0) p0_rdata <= mem_read_data;
    end
  end
  // rst_n gates the strobe so a reset mid-access can never commit a write
  assign mem_MemWrite = rst_n && state == ACCESS && cmd_id == PORT1 && cmd_we;
  assign mem_addr = cmd_addr;
  assign mem_write_data = cmd_wdata;
  assign p0_ack = state == RESP && cmd_id == PORT0;
  assign p1_ack = state == RESP && cmd_id == PORT1;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized scoreboard bench for mem_arbiter plus directed reset and fixed-priority cases
module tb_mem_arbiter;
  logic clk = 0, rst_n = 0;
  logic p0_req = 0, p0_ack, p1_req = 0, p1_we = 0, p1_ack, mem_MemWrite;
  logic [15:0] p0_addr = 0, p1_addr = 0, p1_wdata = 0, p0_rdata, p1_rdata;
  logic [15:0] mem_addr, mem_write_data, mem_read_data;
  logic f_p0_req = 0, f_p1_req = 0, f_p0_ack, f_p1_ack, f_we;
  logic [15:0] f_p0_rdata, f_p1_rdata, f_addr, f_wd;
  logic [15:0] mem [65536];
  logic [15:0] ref_mem [65536];
  int cyc = 0, total = 0, fails = 0, wcnt = 0;
  logic [15:0] waddr, wdat;
  bit last_m = 1;
  typedef struct {bit port; bit we; logic [15:0] addr; logic [15:0] data; int cyc;} exp_t;
  exp_t expq[$];

  mem_arbiter #(.AW(16), .DW(16), .FIX_PRIO(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_ack(p0_ack), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_rdata(p1_rdata),
    .mem_MemWrite(mem_MemWrite), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data));

  mem_arbiter #(.AW(16), .DW(16), .FIX_PRIO(1)) u_fix (
    .clk(clk), .rst_n(rst_n),
    .p0_req(f_p0_req), .p0_addr(16'h0001), .p0_ack(f_p0_ack), .p0_rdata(f_p0_rdata),
    .p1_req(f_p1_req), .p1_we(1'b0), .p1_addr(16'h0002), .p1_wdata(16'h0000),
    .p1_ack(f_p1_ack), .p1_rdata(f_p1_rdata),
    .mem_MemWrite(f_we), .mem_addr(f_addr), .mem_write_data(f_wd),
    .mem_read_data(f_addr ^ 16'h5A5A));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (mem_MemWrite) mem[mem_addr] <= mem_write_data;
  assign mem_read_data = mem[mem_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void predict(input bit port, input bit we, input logic [15:0] a,
                                  input logic [15:0] d, input int c);
    exp_t e;
    e.port = port;
    e.we = port & we;
    e.addr = a;
    e.cyc = c;
    if (e.we) begin
      e.data = d;
      ref_mem[a] = d;
    end else e.data = ref_mem[a];
    last_m = port;
    expq.push_back(e);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) wcnt = 0;
    else begin
      if (p0_ack && p1_ack) chk("both_acks", 2, 1);
      if (p0_ack || p1_ack) begin
        if (expq.size() == 0) chk("unexpected_ack", {p1_ack, p0_ack}, 0);
        else begin
          e = expq.pop_front();
          chk("ack_port", p1_ack, e.port);
          chk("ack_cycle", cyc, e.cyc);
          if (e.we) begin
            chk("write_count", wcnt, 1);
            chk("write_addr", waddr, e.addr);
            chk("write_data", wdat, e.data);
          end else begin
            chk("read_no_write", wcnt, 0);
            chk("rdata", e.port ? p1_rdata : p0_rdata, e.data);
          end
        end
        wcnt = 0;
      end
      if (mem_MemWrite) begin
        wcnt++;
        waddr = mem_addr;
        wdat = mem_write_data;
      end
    end
  end

  // called on the negedge of an IDLE cycle; returns on the negedge of the next IDLE cycle
  task automatic round(input bit r0, input logic [15:0] a0, input bit r1, input bit w1,
                       input logic [15:0] a1, input logic [15:0] d1, input bit perturb);
    bit pend0, pend1, first;
    int t, issue;
    issue = cyc;
    if (r0 && r1) begin
      first = ~last_m;
      predict(first, w1, first ? a1 : a0, d1, issue + 2);
      predict(~first, w1, first ? a0 : a1, d1, issue + 5);
    end else if (r0) predict(0, 0, a0, 0, issue + 2);
    else if (r1) predict(1, w1, a1, d1, issue + 2);
    p0_req = r0; p0_addr = a0;
    p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
    pend0 = r0; pend1 = r1; t = 0;
    while ((pend0 || pend1) && t < 12) begin
      @(negedge clk);
      t++;
      if (perturb && t == 1) begin
        p1_addr = a1 + 16'd1;
        p1_wdata = ~d1;
      end
      if (p0_ack) begin p0_req = 0; pend0 = 0; end
      if (p1_ack) begin p1_req = 0; pend1 = 0; end
    end
    if (pend0 || pend1) chk("ack_timeout", {pend1, pend0}, 0);
    p0_req = 0; p1_req = 0;
    @(negedge clk);
  endtask

  initial begin
    int n0, n1, hold, bad;
    logic [15:0] keep;
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 16'(i * 40503);
      ref_mem[i] = 16'(i * 40503);
    end
    mem[16'h0040] = 16'hBEEF;
    ref_mem[16'h0040] = 16'hBEEF;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_p0_ack", p0_ack, 0);
    chk("reset_p1_ack", p1_ack, 0);
    chk("reset_memwrite", mem_MemWrite, 0);
    chk("reset_p0_rdata", p0_rdata, 0);
    chk("reset_p1_rdata", p1_rdata, 0);
    chk("reset_mem_addr", mem_addr, 0);
    chk("reset_wdata", mem_write_data, 0);
    @(negedge clk);
    rst_n = 1;
    round(1, 16'h0040, 0, 0, 0, 0, 0);
    round(0, 0, 1, 1, 16'h00A0, 16'h1234, 0);
    round(0, 0, 1, 0, 16'h00A0, 0, 0);
    repeat (3) round(1, 16'h0001, 1, 0, 16'h0002, 0, 0);
    round(0, 0, 1, 1, 16'h0005, 16'hAAAA, 1);
    repeat (40)
      round($urandom_range(0, 1), 16'($urandom_range(0, 255)), $urandom_range(0, 1),
            $urandom_range(0, 1), 16'($urandom_range(0, 255)), 16'($urandom), 0);
    keep = ref_mem[16'h0010];
    p1_req = 1; p1_we = 1; p1_addr = 16'h0010; p1_wdata = 16'hFFFF;
    @(posedge clk);
    #3;
    chk("rst_pre_strobe", mem_MemWrite, 1);
    rst_n = 0;
    #1;
    chk("rst_strobe_drop", mem_MemWrite, 0);
    chk("rst_no_ack", {p1_ack, p0_ack}, 0);
    chk("rst_p0_rdata", p0_rdata, 0);
    chk("rst_p1_rdata", p1_rdata, 0);
    chk("rst_mem_addr", mem_addr, 0);
    p1_req = 0; p1_we = 0;
    @(posedge clk);
    #1;
    chk("rst_mem_kept", mem[16'h0010], keep);
    last_m = 1;
    repeat (2) @(negedge clk);
    rst_n = 1;
    round(1, 16'h0040, 1, 0, 16'h0020, 0, 0);
    f_p0_req = 1; f_p1_req = 1; n0 = 0; n1 = 0;
    repeat (12) begin
      @(negedge clk);
      n0 += int'(f_p0_ack);
      n1 += int'(f_p1_ack);
    end
    chk("fix_p0_grants", n0, 4);
    chk("fix_p1_starved", n1, 0);
    chk("fix_p0_rdata", f_p0_rdata, 16'h0001 ^ 16'h5A5A);
    f_p0_req = 0; hold = 0;
    while (!f_p1_ack && hold < 6) begin
      @(negedge clk);
      hold++;
    end
    chk("fix_p1_ack", f_p1_ack, 1);
    chk("fix_p1_wait", hold, 2);
    chk("fix_p1_rdata", f_p1_rdata, 16'h0002 ^ 16'h5A5A);
    f_p1_req = 0;
    repeat (3) @(negedge clk);
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk("mem_final", bad, 0);
    chk("queue_drained", expq.size(), 0);
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter AW, default 16, meaning address width.
REQ-002 The block SHALL have parameter DW, default 16, meaning data width.
REQ-003 The block SHALL have parameter FIX_PRIO, default 0, meaning 0 = round-robin and 1 = port 0 always wins ties.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-005 The ports SHALL be as follows, one per line:
- clk  in  1  clock.
- rst_n  in  1  async active-low reset.
- p0_req  in  1  port 0 (fetch, read-only) request.
- p0_addr  in  AW  port 0 address.
- p0_ack  out  1  port 0 completion pulse.
- p0_rdata  out  DW  port 0 read data.
- p1_req  in  1  port 1 (data) request.
- p1_we  in  1  port 1 write enable.
- p1_addr  in  AW  port 1 address.
- p1_wdata  in  DW  port 1 write data.
- p1_ack  out  1  port 1 completion pulse.
- p1_rdata  out  DW  port 1 read data.
- mem_MemWrite  out  1  memory write strobe.
- mem_addr  out  AW  memory address.
- mem_write_data  out  DW  memory write data.
- mem_read_data  in  DW  memory combinational read data.

Function
REQ-006 The FSM SHALL have three states, IDLE -> ACCESS -> RESP -> IDLE, with no other transitions except reset.
REQ-007 In IDLE with no request pending, the FSM SHALL stay in IDLE.
REQ-008 In IDLE with at least one request pending, the FSM SHALL select a winner, latch the winner's id, addr, we and wdata into a command register, and go to ACCESS.
REQ-009 When only one port requests, that port SHALL win.
REQ-010 When both ports request with FIX_PRIO=0, the port not granted last SHALL win.
REQ-011 When both ports request with FIX_PRIO=1, port 0 SHALL win.
REQ-012 The last-grant register SHALL update only on entry to ACCESS.
REQ-013 In ACCESS, mem_addr and mem_write_data SHALL come from the command register, and mem_MemWrite SHALL be high only if the winner is port 1 with we=1.
REQ-014 Port 0 SHALL never cause a write.
REQ-015 On the clock edge ending ACCESS, the winner's rdata register SHALL capture mem_read_data, for writes as well as reads (write-first value is not guaranteed).
REQ-016 In RESP, the winner's ack SHALL be high for exactly one cycle, and the winner's rdata SHALL be valid.
REQ-017 The FSM SHALL return from RESP to IDLE unconditionally.
REQ-018 Transaction latency SHALL be: request sampled at IDLE edge N, ACCESS in cycle N+1, ack in cycle N+2.
REQ-019 Throughput SHALL be one transaction per 3 cycles.
REQ-020 A requester SHALL hold req, addr, we and wdata stable from assertion until it sees ack.
REQ-021 A req still high in the IDLE cycle after ack SHALL be treated as a new request.
REQ-022 p0_rdata and p1_rdata SHALL each hold their value until that port's next capture.
REQ-023 Changes on requester inputs during ACCESS or RESP SHALL have no effect on the transaction in flight.
REQ-024 Outside ACCESS, mem_MemWrite SHALL be 0, and mem_addr and mem_write_data SHALL hold the command register value.
REQ-025 At no time SHALL p0_ack and p1_ack both be high.

Reset
REQ-026 Asserting rst_n low SHALL immediately force the state to IDLE, mem_MemWrite=0, p0_ack=0, p1_ack=0, p0_rdata=0, p1_rdata=0, command register=0, and last-grant=port 1 (so port 0 wins the first tie).
REQ-027 Reset asserted during ACCESS SHALL drop mem_MemWrite combinationally so that no memory write is committed, and the interrupted transaction SHALL be discarded without ack.
REQ-028 After rst_n deasserts, the first request SHALL be sampled at the first clock edge.

Structure
REQ-029 The state enum (IDLE, ACCESS, RESP), default AW/DW, and port id constants SHALL be placed in a shared package, mem_arb_pkg.
REQ-030 The block SHALL have no sub-module; the round-robin picker, FSM and command register SHALL be implemented inline.

Verification
REQ-031 Port 0 single read: memory preloaded with [0x0040]=0xBEEF; p0_req with addr 0x0040 -> p0_ack in cycle N+2, p0_rdata=0xBEEF, mem_MemWrite never high.
REQ-032 Port 1 write then read: write 0x1234 to 0x00A0, then read 0x00A0 -> mem_MemWrite high exactly one cycle, the read returns 0x1234, and p1_ack pulses twice.
REQ-033 Simultaneous requests with FIX_PRIO=0, held: p0 (0x0001) and p1 (0x0002) asserted continuously -> grants alternate p0, p1, p0, p1, and no port waits more than 3 cycles beyond one peer transaction.
REQ-034 Simultaneous requests with FIX_PRIO=1: p0 held continuously -> p1 is never granted while p0 is requesting.
REQ-035 Reset during ACCESS of a p1 write of 0xFFFF to 0x0010 -> memory[0x0010] unchanged, no ack, and all outputs at reset values.
REQ-036 Input change after grant: p1_addr changed from 0x0005 to 0x0006 during ACCESS -> the access uses 0x0005.
